// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared port indices, size defaults and arbiter state encoding
package noc_pkg;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_EAST  = 3;
    localparam int PORT_WEST  = 4;

    localparam int N_PORTS_DEF = 5;
    localparam int FLIT_W_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic priority pick starting at base
module rr_pick
    import noc_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int BW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [BW-1:0]      base,
    output logic [N_PORTS-1:0] pick,
    output logic               valid
);

    logic [2*N_PORTS-1:0] dbl_req;
    logic [2*N_PORTS-1:0] dbl_pick;
    logic [N_PORTS-1:0]   rot;
    logic [N_PORTS-1:0]   low;

    // Rotate so base lands at bit 0, isolate the lowest set bit, rotate back.
    assign dbl_req  = {req, req} >> base;
    assign rot      = dbl_req[N_PORTS-1:0];
    assign low      = rot & (~rot + 1'b1);
    assign dbl_pick = {low, low} << base;
    assign pick     = dbl_pick[2*N_PORTS-1:N_PORTS];
    assign valid    = |req;

endmodule

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - round-robin packet arbiter feeding one output buffer
module port_arbiter
    import noc_pkg::*;
#(
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int PKT_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*FLIT_W-1:0] flit_in,
    input  logic                      out_full,
    output logic [N_PORTS-1:0]        ack,
    output logic [N_PORTS-1:0]        grant,
    output logic [FLIT_W-1:0]         out_data,
    output logic                      write_req,
    output logic                      busy
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_PORTS - 1);

    state_t             state;
    state_t             state_next;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant_idx;
    logic [CW-1:0]      cnt;
    logic [N_PORTS-1:0] pick;
    logic               pick_valid;
    logic               xfer;
    logic               last_flit;
    logic [FLIT_W-1:0]  grant_flit;

    rr_pick #(
        .N_PORTS(N_PORTS),
        .BW     (PW)
    ) u_rr_pick (
        .req  (req),
        .base (rr_ptr),
        .pick (pick),
        .valid(pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = BUSY;
            BUSY:    if (last_flit)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A stalled owner (req low or buffer full) keeps the output; nobody else is considered.
    always_comb begin
        xfer      = !reset && (state == BUSY) && (|(req & grant)) && !out_full;
        ack       = xfer ? grant : '0;
        last_flit = xfer && (cnt == CNT_LAST);
    end

    always_comb begin
        grant_idx  = '0;
        grant_flit = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) grant_idx = PW'(i);
            grant_flit = grant_flit | (flit_in[i*FLIT_W +: FLIT_W] & {FLIT_W{grant[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            cnt       <= '0;
            grant     <= '0;
            out_data  <= '0;
            write_req <= 1'b0;
        end else begin
            write_req <= xfer;
            if (xfer) out_data <= grant_flit;
            if (state == IDLE && pick_valid) begin
                grant <= pick;
                cnt   <= '0;
            end else if (xfer) begin
                if (last_flit) begin
                    grant  <= '0;
                    rr_ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 The block SHALL have parameter FLIT_W, default 4: flit width in bits.
REQ-002 The block SHALL have parameter N_PORTS, default 5: number of requesting input ports, indexed 0=local, 1=north, 2=south, 3=east, 4=west.
REQ-003 The block SHALL have parameter PKT_LEN, default 4: flits per packet, legal range 1..16.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N_PORTS bits: bit i high means input port i has a valid flit on flit_in.
REQ-007 The block SHALL have port flit_in, input, N_PORTS*FLIT_W bits: port i flit in bits [i*FLIT_W +: FLIT_W].
REQ-008 The block SHALL have port out_full, input, 1 bit: downstream output buffer full; no transfer while high.
REQ-009 The block SHALL have port ack, output, N_PORTS bits: combinational, one-hot or zero; bit i high means the flit of port i is consumed this cycle.
REQ-010 The block SHALL have port grant, output, N_PORTS bits: registered, one-hot or zero; the current owner of the output.
REQ-011 The block SHALL have port out_data, output, FLIT_W bits: registered flit to downstream.
REQ-012 The block SHALL have port write_req, output, 1 bit: registered; out_data is valid and is written downstream this cycle.
REQ-013 The block SHALL have port busy, output, 1 bit: registered; high while the state is BUSY.

Function
REQ-014 The block SHALL implement two states, IDLE and BUSY, with a round-robin pointer rr_ptr (0..N_PORTS-1) and a flit counter cnt (0..PKT_LEN-1).
REQ-015 In IDLE with req nonzero, the block SHALL select the first set req bit at or cyclically after rr_ptr, set grant to that bit one-hot, clear cnt, and enter BUSY on the next edge.
REQ-016 In IDLE, the block SHALL keep ack at zero and transfer no flit.
REQ-017 In BUSY, a transfer SHALL occur in a cycle where (req & grant) is nonzero and out_full is low; ack then equals grant, and is zero otherwise.
REQ-018 On a transfer, the block SHALL register out_data as the granted port's flit and write_req as 1 on the next edge; in every cycle without a transfer, write_req SHALL register 0 and out_data SHALL hold its value.
REQ-019 On a transfer with cnt < PKT_LEN-1, the block SHALL increment cnt and stay in BUSY.
REQ-020 On a transfer with cnt == PKT_LEN-1, the block SHALL clear grant, set rr_ptr to (granted index + 1) mod N_PORTS, and enter IDLE.
REQ-021 If the granted req drops mid-packet, the block SHALL hold grant and cnt indefinitely (no timeout) and ignore all other requests.
REQ-022 Requests arriving during the last-flit cycle SHALL be arbitrated only in the following IDLE cycle (one-cycle bubble between packets).
REQ-023 Latency SHALL be: req sampled in IDLE at cycle t, first ack at the earliest in t+1, first write_req at the earliest in t+2.
REQ-024 For PKT_LEN=1, every packet SHALL be exactly one BUSY cycle with a transfer, followed by a return to IDLE.

Reset
REQ-025 While reset is high, the block SHALL force state IDLE, rr_ptr=0, cnt=0, grant=0, out_data=0, write_req=0 and busy=0, and ack SHALL be 0.
REQ-026 A reset asserted mid-packet SHALL abandon the packet, with arbitration on the first cycle after release starting from port 0.

Structure
REQ-027 The shared package noc_pkg SHALL hold the port index constants (PORT_LOCAL..PORT_WEST), the N_PORTS and FLIT_W defaults, and the IDLE/BUSY state encoding.
REQ-028 Cyclic priority selection SHALL be a combinational sub-module rr_pick, with inputs req and base, producing a one-hot output and a valid flag.

Verification
REQ-029 The bench SHALL cover: reset, then req=5'b00001 with flit_in local held at 4'hA -> grant=00001 at t+1, write_req high on t+2..t+5 with out_data=A, then IDLE.
REQ-030 The bench SHALL cover: all five req held high from reset -> packet grant order 0,1,2,3,4,0, with exactly 4 write_req cycles per packet and one idle bubble between packets.
REQ-031 The bench SHALL cover: north granted, out_full high for 3 cycles after flit 2 -> ack=0 and write_req=0 for those 3 cycles, with cnt held and 4 flits total delivered in order.
REQ-032 The bench SHALL cover: east granted, req[3] dropped for 2 cycles mid-packet while west requests -> grant stays 01000 and west is served only after east's 4th flit.
REQ-033 The bench SHALL cover: reset pulsed after flit 2 of a south packet -> all outputs 0 the next cycle, and with south and local requesting after release, local (port 0) is granted first.
REQ-034 The bench SHALL check on every cycle: ack is one-hot or zero, ack is a subset of grant, and write_req at t+1 equals |ack at t.
